lspc_timer: RTL and testbench
=============================

Name: lspc_timer

Overview:
- Sits directly downstream of the video sync generator and consumes its pixel-rate timing, raster counter and blanking outputs.
- Implements the LSPC programmable raster timer: a 32-bit reloadable down-counter clocked at pixel rate, plus the vertical-blank interrupt source.
- Raises level interrupt requests IRQ_TIMER and IRQ_VBL to the 68k interrupt encoder, with CPU-side reload, mode and acknowledge registers.

Parameters:
- STOP_LO, 9'h010: first raster line (inclusive) on which the timer runs when PAL stop mode is active.
- STOP_HI, 9'h100: raster line (exclusive) at which the timer halts again in PAL stop mode.

Ports:
- CLK_24M  in  1  master clock; all state updates on its rising edge.
- nRESET  in  1  asynchronous active-low reset.
- PIXEL_EN  in  1  one-cycle-in-four enable; each pulse is one 6 MHz pixel tick.
- RASTERC  in  9  current raster line from the video sync generator.
- BNKB  in  1  vertical blank from the video sync generator, high while blanking.
- VMODE  in  1  1 = PAL, 0 = NTSC.
- DATA  in  16  CPU write data.
- WR_MODE  in  1  one-cycle strobe: write mode register (LSPCMODE).
- WR_RLD_HI  in  1  one-cycle strobe: write reload[31:16].
- WR_RLD_LO  in  1  one-cycle strobe: write reload[15:0].
- WR_STOP  in  1  one-cycle strobe: write stop register; DATA[0] = PAL stop enable.
- WR_ACK  in  1  one-cycle strobe: write IRQ acknowledge register.
- IRQ_TIMER  out  1  timer interrupt pending.
- IRQ_VBL  out  1  vertical-blank interrupt pending.
- TIMER_CNT  out  32  current counter value, for debug/trace.

Behaviour:
- Reset: counter = 32'hFFFFFFFF; reload = 0; mode bits = 0; stop = 0; IRQ_TIMER = 0; IRQ_VBL = 0; BNKB edge register = 0. All take effect asynchronously while nRESET = 0.
- Mode register, captured on WR_MODE:
  - DATA[4] = timer IRQ enable (TEN).
  - DATA[5] = reload on low-word write (RLW).
  - DATA[6] = reload at vblank start (RLV).
  - DATA[7] = reload on zero (RLZ).
- Stop register: DATA[0] captured on WR_STOP; all other DATA bits ignored.
- Halted: asserted when stop = 1, VMODE = 1 and (RASTERC < STOP_LO or RASTERC >= STOP_HI). When halted, PIXEL_EN ticks are ignored.
- Vblank start (VBS): single-cycle pulse when BNKB = 1 and its registered copy = 0.
- Counter update priority, highest first, evaluated each cycle:
  1. WR_RLD_LO with RLW = 1: counter ← {reload_hi, DATA} in the same write cycle. The new low word is used directly; there is no one-cycle stale value.
  2. VBS with RLV = 1: counter ← reload.
  3. PIXEL_EN tick, not halted, counter == 0:
     - counter ← reload if RLZ = 1, else 32'hFFFFFFFF.
     - If TEN = 1, set IRQ_TIMER.
  4. PIXEL_EN tick, not halted, counter != 0: counter ← counter − 1.
- Reload registers update on their strobes regardless of RLW.
- Zero is sampled only on a tick:
  - A counter loaded with 0 fires on the next non-halted tick.
  - Reload = 0 with RLZ = 1 fires on every tick.
- IRQ_VBL: set on every VBS, independent of mode bits.
- WR_ACK clears flags:
  - DATA[1] = 1 clears IRQ_TIMER.
  - DATA[2] = 1 clears IRQ_VBL.
  - If a set and an ack of the same flag occur in the same cycle, set wins (flag stays 1).
- Latency:
  - IRQ outputs are registered and assert the cycle after the causing tick or VBS edge.
  - TIMER_CNT is the counter register, with no extra latency.
- Clearing TEN does not clear an already pending IRQ_TIMER.
- Reset mid-count returns everything to reset values immediately. After release, the first rising BNKB edge is detected normally; a BNKB already high at release produces no VBS.
- Counter wraps from 0 to 32'hFFFFFFFF when RLZ = 0; there is no saturation.

Test Plan:
- Reload = 32'h00000003, mode 0xB0 (TEN | RLW | RLZ), write low -> IRQ_TIMER rises one cycle after the 4th PIXEL_EN tick; counter reads 3 again; flag recurs every 4 ticks.
- Mode 0x10 (RLZ = 0), counter loaded to 1 -> after 2 ticks TIMER_CNT = 32'hFFFFFFFF and IRQ_TIMER = 1; WR_ACK with DATA = 16'h0002 clears it next cycle.
- BNKB 0→1 with RLV = 1 and reload = 32'h1234 -> TIMER_CNT = 32'h1234 and IRQ_VBL = 1 one cycle after the edge. Holding BNKB high gives no second VBS.
- VMODE = 1, stop = 1, RASTERC = 9'h008 with PIXEL_EN toggling -> counter unchanged. RASTERC = 9'h010 -> decrement resumes. VMODE = 0 -> never halts.
- Simultaneous: WR_ACK DATA[1] = 1 on the cycle the timer fires -> IRQ_TIMER stays 1. WR_RLD_LO (RLW = 1) on the same cycle as VBS (RLV = 1) -> counter takes the written value.
- nRESET pulsed low mid-count with IRQs pending -> IRQ_TIMER = IRQ_VBL = 0 and TIMER_CNT = 32'hFFFFFFFF immediately, with no clock edge needed.

Source files
------------

// File: rtl/lspc_timer.sv
// rtl/lspc_timer.sv - LSPC programmable raster timer with timer and vblank interrupt sources
module lspc_timer #(
    parameter logic [8:0] STOP_LO = 9'h010,
    parameter logic [8:0] STOP_HI = 9'h100
) (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic        PIXEL_EN,
    input  logic [8:0]  RASTERC,
    input  logic        BNKB,
    input  logic        VMODE,
    input  logic [15:0] DATA,
    input  logic        WR_MODE,
    input  logic        WR_RLD_HI,
    input  logic        WR_RLD_LO,
    input  logic        WR_STOP,
    input  logic        WR_ACK,
    output logic        IRQ_TIMER,
    output logic        IRQ_VBL,
    output logic [31:0] TIMER_CNT
);

    logic [31:0] counter;
    logic [31:0] counter_nxt;
    logic [15:0] reload_hi;
    logic [15:0] reload_lo;
    logic [31:0] reload;
    logic        ten;
    logic        rlw;
    logic        rlv;
    logic        rlz;
    logic        stop_en;
    logic        bnkb_q;
    logic        armed;
    logic        halted;
    logic        tick;
    logic        vbs;
    logic        fire;
    logic        irq_timer;
    logic        irq_vbl;

    assign reload = {reload_hi, reload_lo};
    assign halted = stop_en & VMODE & ((RASTERC < STOP_LO) | (RASTERC >= STOP_HI));
    assign tick   = PIXEL_EN & ~halted;
    // armed stays low for the first cycle after reset so a BNKB that is
    // already high at release is not mistaken for a fresh blanking edge.
    assign vbs    = armed & BNKB & ~bnkb_q;

    always_comb begin
        counter_nxt = counter;
        fire        = 1'b0;
        if (WR_RLD_LO && rlw) begin
            counter_nxt = {reload_hi, DATA};
        end else if (vbs && rlv) begin
            counter_nxt = reload;
        end else if (tick) begin
            if (counter == 32'd0) begin
                fire        = 1'b1;
                counter_nxt = rlz ? reload : 32'hFFFF_FFFF;
            end else begin
                counter_nxt = counter - 32'd1;
            end
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            counter <= 32'hFFFF_FFFF;
        end else begin
            counter <= counter_nxt;
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            reload_hi <= 16'h0000;
            reload_lo <= 16'h0000;
            ten       <= 1'b0;
            rlw       <= 1'b0;
            rlv       <= 1'b0;
            rlz       <= 1'b0;
            stop_en   <= 1'b0;
        end else begin
            if (WR_RLD_HI) begin
                reload_hi <= DATA;
            end
            if (WR_RLD_LO) begin
                reload_lo <= DATA;
            end
            if (WR_MODE) begin
                ten <= DATA[4];
                rlw <= DATA[5];
                rlv <= DATA[6];
                rlz <= DATA[7];
            end
            if (WR_STOP) begin
                stop_en <= DATA[0];
            end
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            bnkb_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            bnkb_q <= BNKB;
            armed  <= 1'b1;
        end
    end

    // A set arriving in the same cycle as its acknowledge wins.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            irq_timer <= 1'b0;
            irq_vbl   <= 1'b0;
        end else begin
            irq_timer <= (fire & ten) | (irq_timer & ~(WR_ACK & DATA[1]));
            irq_vbl   <= vbs | (irq_vbl & ~(WR_ACK & DATA[2]));
        end
    end

    assign IRQ_TIMER = irq_timer;
    assign IRQ_VBL   = irq_vbl;
    assign TIMER_CNT = counter;

endmodule

// File: tb/tb_lspc_timer.sv
// tb/tb_lspc_timer.sv - table-driven scoreboard bench for lspc_timer
module tb_lspc_timer;

    logic        clk;
    logic        rst_n;
    logic        pixel_en;
    logic [8:0]  rasterc;
    logic        bnkb;
    logic        vmode;
    logic [15:0] data;
    logic        wr_mode;
    logic        wr_rld_hi;
    logic        wr_rld_lo;
    logic        wr_stop;
    logic        wr_ack;
    logic        irq_timer;
    logic        irq_vbl;
    logic [31:0] timer_cnt;

    lspc_timer dut (
        .CLK_24M   (clk),
        .nRESET    (rst_n),
        .PIXEL_EN  (pixel_en),
        .RASTERC   (rasterc),
        .BNKB      (bnkb),
        .VMODE     (vmode),
        .DATA      (data),
        .WR_MODE   (wr_mode),
        .WR_RLD_HI (wr_rld_hi),
        .WR_RLD_LO (wr_rld_lo),
        .WR_STOP   (wr_stop),
        .WR_ACK    (wr_ack),
        .IRQ_TIMER (irq_timer),
        .IRQ_VBL   (irq_vbl),
        .TIMER_CNT (timer_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [4:0] W_MODE = 5'b10000;
    localparam logic [4:0] W_HI   = 5'b01000;
    localparam logic [4:0] W_LO   = 5'b00100;
    localparam logic [4:0] W_STOP = 5'b00010;
    localparam logic [4:0] W_ACK  = 5'b00001;
    localparam logic [4:0] W_NONE = 5'b00000;

    typedef struct {
        logic        pix;
        logic        bnkb;
        logic [8:0]  rc;
        logic        vmode;
        logic [4:0]  wr;
        logic [15:0] data;
        logic [31:0] cnt;
        logic        it;
        logic        iv;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] cnt;
        logic        it;
        logic        iv;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic pix, logic bk, logic [8:0] rc, logic vm, logic [4:0] wr,
                                logic [15:0] d, logic [31:0] cnt, logic it, logic iv);
        vec_t v;
        v.pix = pix; v.bnkb = bk; v.rc = rc; v.vmode = vm; v.wr = wr; v.data = d;
        v.cnt = cnt; v.it = it; v.iv = iv;
        return v;
    endfunction

    task automatic check(input int id, input logic [31:0] cnt, input logic it, input logic iv);
        n_vec++;
        if (timer_cnt !== cnt || irq_timer !== it || irq_vbl !== iv) begin
            n_bad++;
            $display("FAIL step%0d: got cnt=%h irq_timer=%b irq_vbl=%b, expected cnt=%h irq_timer=%b irq_vbl=%b",
                     id, timer_cnt, irq_timer, irq_vbl, cnt, it, iv);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, pop and compare after the edge.
    task automatic apply(input vec_t v, input int id);
        exp_t e;
        exp_t got;
        pixel_en  = v.pix;
        bnkb      = v.bnkb;
        rasterc   = v.rc;
        vmode     = v.vmode;
        data      = v.data;
        wr_mode   = v.wr[4];
        wr_rld_hi = v.wr[3];
        wr_rld_lo = v.wr[2];
        wr_stop   = v.wr[1];
        wr_ack    = v.wr[0];
        e.id = id; e.cnt = v.cnt; e.it = v.it; e.iv = v.iv;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL step%0d: scoreboard empty, got cnt=%h, expected an entry", id, timer_cnt);
        end else begin
            got = sb.pop_front();
            check(got.id, got.cnt, got.it, got.iv);
        end
    endtask

    initial begin
        // test 1: reload 3, TEN|RLW|RLZ
        vecs.push_back(mk(0, 0, 9'h0, 0, W_MODE, 16'h00B0, 32'hFFFFFFFF, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_HI,   16'h0000, 32'hFFFFFFFF, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_LO,   16'h0003, 32'h00000003, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000002, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000002, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000001, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000003, 1, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_ACK,  16'h0002, 32'h00000003, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000002, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000001, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000003, 1, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_ACK,  16'h0002, 32'h00000003, 0, 0));
        // test 2: RLZ = 0 wraps to all-ones
        vecs.push_back(mk(0, 0, 9'h0, 0, W_MODE, 16'h0030, 32'h00000003, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_LO,   16'h0001, 32'h00000001, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_MODE, 16'h0010, 32'h00000001, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'hFFFFFFFF, 1, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_ACK,  16'h0002, 32'hFFFFFFFF, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'hFFFFFFFE, 0, 0));
        // test 3: vblank reload and IRQ_VBL
        vecs.push_back(mk(0, 0, 9'h0, 0, W_LO,   16'h1234, 32'hFFFFFFFE, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_MODE, 16'h0040, 32'hFFFFFFFE, 0, 0));
        vecs.push_back(mk(0, 1, 9'h0, 0, W_NONE, 16'h0000, 32'h00001234, 0, 1));
        vecs.push_back(mk(0, 1, 9'h0, 0, W_NONE, 16'h0000, 32'h00001234, 0, 1));
        vecs.push_back(mk(0, 1, 9'h0, 0, W_ACK,  16'h0004, 32'h00001234, 0, 0));
        vecs.push_back(mk(0, 1, 9'h0, 0, W_NONE, 16'h0000, 32'h00001234, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00001234, 0, 0));
        // test 4: PAL stop window
        vecs.push_back(mk(0, 0, 9'h0,   0, W_STOP, 16'hFFFF, 32'h00001234, 0, 0));
        vecs.push_back(mk(1, 0, 9'h008, 1, W_NONE, 16'h0000, 32'h00001234, 0, 0));
        vecs.push_back(mk(1, 0, 9'h008, 1, W_NONE, 16'h0000, 32'h00001234, 0, 0));
        vecs.push_back(mk(1, 0, 9'h010, 1, W_NONE, 16'h0000, 32'h00001233, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0FF, 1, W_NONE, 16'h0000, 32'h00001232, 0, 0));
        vecs.push_back(mk(1, 0, 9'h100, 1, W_NONE, 16'h0000, 32'h00001232, 0, 0));
        vecs.push_back(mk(1, 0, 9'h100, 0, W_NONE, 16'h0000, 32'h00001231, 0, 0));
        vecs.push_back(mk(1, 0, 9'h008, 0, W_NONE, 16'h0000, 32'h00001230, 0, 0));
        // test 5: simultaneous events
        vecs.push_back(mk(0, 0, 9'h0, 0, W_STOP, 16'h0000, 32'h00001230, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_MODE, 16'h00B0, 32'h00001230, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_LO,   16'h0001, 32'h00000001, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_ACK,  16'h0002, 32'h00000001, 1, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000001, 1, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_MODE, 16'h00F0, 32'h00000001, 1, 0));
        vecs.push_back(mk(0, 1, 9'h0, 0, W_LO,   16'h5555, 32'h00005555, 1, 1));
        vecs.push_back(mk(0, 1, 9'h0, 0, W_ACK,  16'h0006, 32'h00005555, 0, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00005555, 0, 0));
        // reload 0 with RLZ fires on every tick
        vecs.push_back(mk(0, 0, 9'h0, 0, W_LO,   16'h0000, 32'h00000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000000, 1, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_ACK,  16'h0002, 32'h00000000, 1, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_ACK,  16'h0002, 32'h00000000, 0, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'h00000000, 1, 0));
        vecs.push_back(mk(0, 0, 9'h0, 0, W_HI,   16'hABCD, 32'h00000000, 1, 0));
        vecs.push_back(mk(1, 0, 9'h0, 0, W_NONE, 16'h0000, 32'hABCD0000, 1, 0));

        rst_n = 1'b1;
        pixel_en = 1'b0; bnkb = 1'b0; rasterc = 9'h0; vmode = 1'b0; data = 16'h0;
        wr_mode = 1'b0; wr_rld_hi = 1'b0; wr_rld_lo = 1'b0; wr_stop = 1'b0; wr_ack = 1'b0;
        #1 rst_n = 1'b0;
        #2 check(0, 32'hFFFFFFFF, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i + 1);

        // asynchronous reset mid-count with both IRQs pending
        apply(mk(0, 1, 9'h0, 0, W_NONE, 16'h0000, 32'hABCD0000, 1, 1), 100);
        #2 rst_n = 1'b0;
        #1 check(101, 32'hFFFFFFFF, 1'b0, 1'b0);
        @(negedge clk);
        check(102, 32'hFFFFFFFF, 1'b0, 1'b0);
        rst_n = 1'b1;
        // BNKB already high at release: no vblank start
        apply(mk(0, 1, 9'h0, 0, W_NONE, 16'h0000, 32'hFFFFFFFF, 0, 0), 103);
        apply(mk(0, 1, 9'h0, 0, W_NONE, 16'h0000, 32'hFFFFFFFF, 0, 0), 104);
        apply(mk(0, 0, 9'h0, 0, W_NONE, 16'h0000, 32'hFFFFFFFF, 0, 0), 105);
        apply(mk(0, 1, 9'h0, 0, W_NONE, 16'h0000, 32'hFFFFFFFF, 0, 1), 106);
        apply(mk(1, 1, 9'h0, 0, W_NONE, 16'h0000, 32'hFFFFFFFE, 0, 1), 107);

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
